penguin_motion: RTL and testbench

Registered penguin position controller for the Overcooked datapath. Once per video frame it samples the keyboard keycode, consults the four wall-collision flags for the penguin's current position, and advances `penguinX`/`penguinY` by a fixed step when the move is not blocked. It feeds the position to the touching-wall detectors, consumes their flags, and also drives the facing direction and walk-animation frame used by the sprite renderer.

---
 rtl/penguin_motion.sv | 156 +++++++++++++++
 tb/tb_penguin_motion.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/penguin_motion.sv
// Penguin position/animation controller: one evaluated move per frame_clk rise, outputs update one Clk after the tick.
// Latency 1 Clk from the tick cycle; no backpressure, inputs are sampled only in the tick cycle.
module penguin_motion #(
    parameter int unsigned STEP    = 2,
    parameter int unsigned START_X = 320,
    parameter int unsigned START_Y = 300,
    parameter int unsigned X_MIN   = 20,
    parameter int unsigned X_MAX   = 600,
    parameter int unsigned Y_MIN   = 20,
    parameter int unsigned Y_MAX   = 440
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       touchingUpWallFlag,
    input  logic       touchingDownWallFlag,
    input  logic       touchingLeftWallFlag,
    input  logic       touchingRightWallFlag,
    output logic [9:0] penguinX,
    output logic [9:0] penguinY,
    output logic [1:0] facing,
    output logic       moving,
    output logic [1:0] animFrame
);

    localparam logic [9:0] STEP_W  = 10'(STEP);
    localparam logic [9:0] START_XW = 10'(START_X);
    localparam logic [9:0] START_YW = 10'(START_Y);
    localparam logic [9:0] X_MIN_W = 10'(X_MIN);
    localparam logic [9:0] X_MAX_W = 10'(X_MAX);
    localparam logic [9:0] Y_MIN_W = 10'(Y_MIN);
    localparam logic [9:0] Y_MAX_W = 10'(Y_MAX);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic {IDLE, WALK} state_t;

    state_t     state_q, state_d;
    logic       frame_q;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [1:0] facing_q, facing_d;
    logic [2:0] step_cnt_q, step_cnt_d;
    logic [1:0] anim_q, anim_d;

    logic       tick;
    logic       key_vld;
    logic [1:0] key_dir;
    logic       blocked;
    logic [9:0] x_tgt, y_tgt;
    logic       move;

    assign tick = frame_clk & ~frame_q;

    always_comb begin
        key_vld = 1'b1;
        key_dir = DIR_UP;
        case (keycode)
            8'h1A:   key_dir = DIR_UP;
            8'h16:   key_dir = DIR_DOWN;
            8'h04:   key_dir = DIR_LEFT;
            8'h07:   key_dir = DIR_RIGHT;
            default: key_vld = 1'b0;
        endcase
    end

    // Bounds are compared before subtracting/adding so nothing wraps in 10 bits.
    always_comb begin
        x_tgt   = x_q;
        y_tgt   = y_q;
        blocked = 1'b1;
        case (key_dir)
            DIR_UP: begin
                blocked = touchingUpWallFlag;
                y_tgt   = (y_q < Y_MIN_W + STEP_W) ? Y_MIN_W : y_q - STEP_W;
            end
            DIR_DOWN: begin
                blocked = touchingDownWallFlag;
                y_tgt   = (y_q > Y_MAX_W - STEP_W) ? Y_MAX_W : y_q + STEP_W;
            end
            DIR_LEFT: begin
                blocked = touchingLeftWallFlag;
                x_tgt   = (x_q < X_MIN_W + STEP_W) ? X_MIN_W : x_q - STEP_W;
            end
            default: begin
                blocked = touchingRightWallFlag;
                x_tgt   = (x_q > X_MAX_W - STEP_W) ? X_MAX_W : x_q + STEP_W;
            end
        endcase
        move = key_vld & ~blocked & ((x_tgt != x_q) | (y_tgt != y_q));
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        facing_d   = facing_q;
        step_cnt_d = step_cnt_q;
        anim_d     = anim_q;
        if (tick) begin
            if (key_vld) begin
                facing_d = key_dir;
            end
            if (move) begin
                state_d = WALK;
                x_d     = x_tgt;
                y_d     = y_tgt;
                if (state_q == IDLE) begin
                    step_cnt_d = 3'd1;
                    anim_d     = 2'd0;
                end else begin
                    step_cnt_d = step_cnt_q + 3'd1;
                    if (step_cnt_q == 3'd7) begin
                        anim_d = anim_q + 2'd1;
                    end
                end
            end else begin
                state_d    = IDLE;
                step_cnt_d = 3'd0;
                anim_d     = 2'd0;
            end
        end
    end

    // frame_q resets high so a frame_clk already high at release is not a tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q    <= 1'b1;
            state_q    <= IDLE;
            x_q        <= START_XW;
            y_q        <= START_YW;
            facing_q   <= DIR_DOWN;
            step_cnt_q <= 3'd0;
            anim_q     <= 2'd0;
        end else begin
            frame_q    <= frame_clk;
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            facing_q   <= facing_d;
            step_cnt_q <= step_cnt_d;
            anim_q     <= anim_d;
        end
    end

    assign penguinX  = x_q;
    assign penguinY  = y_q;
    assign facing    = facing_q;
    assign moving    = (state_q == WALK);
    assign animFrame = anim_q;

endmodule

// File: tb/tb_penguin_motion.sv
// Directed bench for penguin_motion: table of single-tick vectors plus hand sequences for bounds, animation and reset.
module tb_penguin_motion;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b1;
    logic [7:0] keycode = 8'h07;
    logic [3:0] flags = 4'h0;   // {up, down, left, right}
    logic [9:0] penguinX, penguinY;
    logic [1:0] facing, animFrame;
    logic       moving;

    int checks = 0;
    int failures = 0;
    logic [9:0] pre_x, pre_y;

    penguin_motion dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .frame_clk            (frame_clk),
        .keycode              (keycode),
        .touchingUpWallFlag   (flags[3]),
        .touchingDownWallFlag (flags[2]),
        .touchingLeftWallFlag (flags[1]),
        .touchingRightWallFlag(flags[0]),
        .penguinX             (penguinX),
        .penguinY             (penguinY),
        .facing               (facing),
        .moving               (moving),
        .animFrame            (animFrame)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] key;
        logic [3:0] fl;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] f;
        logic       m;
        logic [1:0] a;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int x, input int y, input int f, input int m, input int a);
        chk({name, ".x"}, int'(penguinX), x);
        chk({name, ".y"}, int'(penguinY), y);
        chk({name, ".facing"}, int'(facing), f);
        chk({name, ".moving"}, int'(moving), m);
        chk({name, ".anim"}, int'(animFrame), a);
    endtask

    // Low phase carries junk key/flags; real values appear only with the rising frame_clk.
    task automatic do_tick(input logic [7:0] key, input logic [3:0] fl);
        @(negedge Clk);
        frame_clk = 1'b0;
        keycode   = 8'h04;
        flags     = 4'hF;
        @(negedge Clk);
        keycode   = key;
        flags     = fl;
        frame_clk = 1'b1;
        pre_x     = penguinX;
        pre_y     = penguinY;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h07, 4'h0, 10'd322, 10'd300, 2'd3, 1'b1, 2'd0};
        vecs[1] = '{8'h07, 4'h1, 10'd322, 10'd300, 2'd3, 1'b0, 2'd0};
        vecs[2] = '{8'h04, 4'h0, 10'd320, 10'd300, 2'd2, 1'b1, 2'd0};
        vecs[3] = '{8'h1A, 4'h0, 10'd320, 10'd298, 2'd0, 1'b1, 2'd0};
        vecs[4] = '{8'h16, 4'h4, 10'd320, 10'd298, 2'd1, 1'b0, 2'd0};
        vecs[5] = '{8'h00, 4'h0, 10'd320, 10'd298, 2'd1, 1'b0, 2'd0};
        vecs[6] = '{8'h55, 4'h0, 10'd320, 10'd298, 2'd1, 1'b0, 2'd0};
        vecs[7] = '{8'h16, 4'h0, 10'd320, 10'd300, 2'd1, 1'b1, 2'd0};
        vecs[8] = '{8'h1A, 4'h2, 10'd320, 10'd298, 2'd0, 1'b1, 2'd0};
        vecs[9] = '{8'h04, 4'h8, 10'd318, 10'd298, 2'd2, 1'b1, 2'd0};

        // Reset with frame_clk high and D held: no step right after release.
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_all("reset", 320, 300, 1, 0, 0);
        repeat (2) @(negedge Clk);
        chk("reset_nostep.x", int'(penguinX), 320);

        // D for 5 ticks: X moves only on the edge after each tick.
        for (int i = 1; i <= 5; i++) begin
            do_tick(8'h07, 4'h0);
            chk($sformatf("d%0d.pre_x", i), int'(pre_x), 320 + 2 * (i - 1));
            chk($sformatf("d%0d.x", i), int'(penguinX), 320 + 2 * i);
        end
        chk_all("d_end", 330, 300, 3, 1, 0);
        repeat (3) @(negedge Clk);
        chk("d_hold.x", int'(penguinX), 330);

        // W blocked by up wall.
        do_tick(8'h1A, 4'h8);
        chk_all("w_blocked", 330, 300, 0, 0, 0);

        // S for 16 ticks: animFrame steps every 8 move ticks.
        for (int i = 1; i <= 16; i++) begin
            do_tick(8'h16, 4'h0);
            if (i == 7)  chk("s7.anim", int'(animFrame), 0);
            if (i == 8)  chk("s8.anim", int'(animFrame), 1);
            if (i == 15) chk("s15.anim", int'(animFrame), 1);
        end
        chk_all("s16", 330, 332, 1, 1, 2);
        do_tick(8'h00, 4'h0);
        chk_all("s_release", 330, 332, 1, 0, 0);

        // Single-tick vector table from the reset position.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_tick(vecs[i].key, vecs[i].fl);
            chk_all($sformatf("vec%0d", i), int'(vecs[i].x), int'(vecs[i].y),
                    int'(vecs[i].f), int'(vecs[i].m), int'(vecs[i].a));
        end

        // A for 151 ticks: reaches X_MIN on tick 150, clamps on 151.
        do_reset();
        for (int i = 1; i <= 151; i++) begin
            do_tick(8'h04, 4'h0);
            if (i == 150) begin
                chk("a150.x", int'(penguinX), 20);
                chk("a150.moving", int'(moving), 1);
            end
        end
        chk_all("a151", 20, 300, 2, 0, 0);

        // S for 71 ticks: reaches Y_MAX on tick 70, clamps on 71.
        for (int i = 1; i <= 71; i++) begin
            do_tick(8'h16, 4'h0);
            if (i == 70) chk("s70.y", int'(penguinY), 440);
        end
        chk_all("s71", 20, 440, 1, 0, 0);

        // Reset landing in a tick cycle mid-walk.
        do_tick(8'h07, 4'h0);
        chk_all("pre_rst_walk", 22, 440, 3, 1, 0);
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        keycode   = 8'h07;
        flags     = 4'h0;
        frame_clk = 1'b1;
        Reset     = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk_all("rst_in_tick", 320, 300, 1, 0, 0);
        repeat (2) @(negedge Clk);
        chk("rst_in_tick_hold.x", int'(penguinX), 320);
        do_tick(8'h07, 4'h0);
        chk_all("post_rst_tick", 322, 300, 3, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
